// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-lights controller.
// Contents:
//   f1_state_t  - controller states (IDLE, SEQ, DELAY, GO, DONE, FAULT)
//   LIGHTS_FULL - f1_fsm output value with all eight lights lit
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEQ,
    DELAY,
    GO,
    DONE,
    FAULT
  } f1_state_t;

  localparam logic [7:0] LIGHTS_FULL = 8'hFF;

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR used to randomise the hold time before
// lights-out. Feedback taps x^W + x^(W-1) + 1 (x^7 + x^6 + 1 at W=7).
// Ports:
//   clk - system clock
//   rst - asynchronous active-low reset (register returns to 1)
//   en  - advance one step on this clock
//   q   - current LFSR value, never all-zero
module f1_lfsr #(
  parameter int LFSR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;
  logic [LFSR_W-1:0] w_nxt;

  assign w_fb  = r_q[LFSR_W-1] ^ r_q[LFSR_W-2];
  assign w_nxt = {r_q[LFSR_W-2:0], w_fb};

  // The all-zero state is a lock-up state; steer out of it if ever reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= LFSR_W'(1);
    end else if (en) begin
      r_q <= (w_nxt == '0) ? LFSR_W'(1) : w_nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/f1_start_controller.sv
// Sequencer for the F1 start-lights game. Starts the light ramp on a
// trigger, holds all lights lit for MIN_DELAY + random ticks, switches the
// lights off and then measures the driver's reaction time in ticks.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   trigger     - start button (asynchronous level)
//   react       - reaction button (asynchronous level)
//   tick        - one-cycle time-unit pulse from clktick
//   lights      - current f1_fsm light pattern
//   seq_en      - f1_fsm step enable (tick while ramping)
//   seq_clr     - one-cycle synchronous clear to f1_fsm
//   lights_out  - high from lights-out until the next start
//   react_time  - measured reaction time in ticks (saturating)
//   time_valid  - react_time holds a valid result
//   false_start - reaction pressed before lights-out
module f1_start_controller
  import f1_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int LFSR_W    = 7,
  parameter int MIN_DELAY = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             react,
  input  logic             tick,
  input  logic [7:0]       lights,
  output logic             seq_en,
  output logic             seq_clr,
  output logic             lights_out,
  output logic [CNT_W-1:0] react_time,
  output logic             time_valid,
  output logic             false_start
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  f1_state_t        r_state, w_state_nxt;
  logic             r_trig_s1, r_trig_s2, r_trig_s3;
  logic             r_react_s1, r_react_s2, r_react_s3;
  logic             w_trig_rise, w_react_rise;
  logic [LFSR_W-1:0] w_lfsr;
  logic [CNT_W-1:0] r_dly, r_dcnt, r_rcnt, r_react_time;
  logic [CNT_W-1:0] w_dly_calc;
  logic             r_lights_out, r_time_valid, r_false_start;
  logic             w_seq_clr, w_dly_load, w_dcnt_inc, w_rcnt_clr, w_rcnt_inc;
  logic             w_go_set, w_fault_set, w_result_load, w_restart;

  f1_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (w_lfsr)
  );

  // Two flops resynchronise the pads; the third holds the previous value
  // for rising-edge detection (3 clocks from pad edge to FSM action).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_trig_s1, r_trig_s2, r_trig_s3}    <= 3'b000;
      {r_react_s1, r_react_s2, r_react_s3} <= 3'b000;
    end else begin
      {r_trig_s1, r_trig_s2, r_trig_s3}    <= {trigger, r_trig_s1, r_trig_s2};
      {r_react_s1, r_react_s2, r_react_s3} <= {react, r_react_s1, r_react_s2};
    end
  end

  assign w_trig_rise  = r_trig_s2 & ~r_trig_s3;
  assign w_react_rise = r_react_s2 & ~r_react_s3;
  assign w_dly_calc   = CNT_W'(MIN_DELAY) + CNT_W'(w_lfsr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // A reaction edge is checked before ramp/delay completion so that a
  // press coinciding with lights-out still counts as a false start.
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_clr     = 1'b0;
    w_dly_load    = 1'b0;
    w_dcnt_inc    = 1'b0;
    w_rcnt_clr    = 1'b0;
    w_rcnt_inc    = 1'b0;
    w_go_set      = 1'b0;
    w_fault_set   = 1'b0;
    w_result_load = 1'b0;
    w_restart     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig_rise) begin
          w_seq_clr   = 1'b1;
          w_state_nxt = SEQ;
        end
      end
      SEQ: begin
        if (w_react_rise) begin
          w_seq_clr   = 1'b1;
          w_fault_set = 1'b1;
          w_state_nxt = FAULT;
        end else if (lights == LIGHTS_FULL) begin
          w_dly_load  = 1'b1;
          w_state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (w_react_rise) begin
          w_seq_clr   = 1'b1;
          w_fault_set = 1'b1;
          w_state_nxt = FAULT;
        end else if (r_dcnt == r_dly) begin
          w_seq_clr   = 1'b1;
          w_go_set    = 1'b1;
          w_rcnt_clr  = 1'b1;
          w_state_nxt = GO;
        end else if (tick) begin
          w_dcnt_inc  = 1'b1;
        end
      end
      GO: begin
        // A tick arriving with the press is deliberately not counted.
        if (w_react_rise) begin
          w_result_load = 1'b1;
          w_state_nxt   = DONE;
        end else if (tick && (r_rcnt != CNT_MAX)) begin
          w_rcnt_inc    = 1'b1;
        end
      end
      DONE, FAULT: begin
        if (w_trig_rise) begin
          w_seq_clr   = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = SEQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dly         <= '0;
      r_dcnt        <= '0;
      r_rcnt        <= '0;
      r_react_time  <= '0;
      r_lights_out  <= 1'b0;
      r_time_valid  <= 1'b0;
      r_false_start <= 1'b0;
    end else begin
      if (w_dly_load) begin
        r_dly  <= w_dly_calc;
        r_dcnt <= '0;
      end else if (w_dcnt_inc) begin
        r_dcnt <= r_dcnt + CNT_W'(1);
      end

      if (w_rcnt_clr)      r_rcnt <= '0;
      else if (w_rcnt_inc) r_rcnt <= r_rcnt + CNT_W'(1);

      if (w_restart) begin
        r_react_time  <= '0;
        r_lights_out  <= 1'b0;
        r_time_valid  <= 1'b0;
        r_false_start <= 1'b0;
      end else begin
        if (w_go_set)    r_lights_out  <= 1'b1;
        if (w_fault_set) r_false_start <= 1'b1;
        if (w_result_load) begin
          r_react_time <= r_rcnt;
          r_time_valid <= 1'b1;
        end
      end
    end
  end

  assign seq_en      = (r_state == SEQ) & tick;
  assign seq_clr     = w_seq_clr;
  assign lights_out  = r_lights_out;
  assign react_time  = r_react_time;
  assign time_valid  = r_time_valid;
  assign false_start = r_false_start;

endmodule
